// File: rtl/mmio_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_fifo_ctrl
// Description : MMIO-driven sequencer for the AFU 64-bit FIFO: push/pop via
//               the DATA port, STATUS/CTRL/THRESH registers, 2-cycle reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_fifo_ctrl #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] ADDR_DATA   = 16'h0020,
    parameter logic [15:0] ADDR_STATUS = 16'h0022,
    parameter logic [15:0] ADDR_CTRL   = 16'h0024,
    parameter logic [15:0] ADDR_THRESH = 16'h0026
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic [15:0] mmio_wr_addr,
    input  logic [63:0] mmio_wr_data,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_rd_addr,
    input  logic [8:0]  mmio_rd_tid,
    output logic        fifo_push,
    output logic [63:0] fifo_wdata,
    output logic        fifo_pop,
    output logic        fifo_clr,
    input  logic [63:0] fifo_rdata,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        thresh_hit
);

    localparam int            CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_thresh;
    logic          r_ovf;
    logic          r_udf;
    logic          r_thresh_hit;

    logic          r_s1_valid;
    logic [8:0]    r_s1_tid;
    logic          r_s1_pop;
    logic [63:0]   r_s1_data;
    logic          r_s2_valid;
    logic [8:0]    r_s2_tid;
    logic          r_s2_pop;
    logic [63:0]   r_s2_data;

    logic          r_fifo_push;
    logic [63:0]   r_fifo_wdata;
    logic          r_fifo_pop;
    logic          r_fifo_clr;

    logic          w_empty;
    logic          w_full;
    logic          w_wr_data;
    logic          w_rd_data;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_clr;
    logic          w_sticky_clr;
    logic [CW-1:0] w_count_nxt;
    logic [63:0]   w_status;
    logic [63:0]   w_rd_word;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_full);
    assign w_wr_data    = mmio_wr_valid && (mmio_wr_addr == ADDR_DATA);
    assign w_rd_data    = mmio_rd_valid && (mmio_rd_addr == ADDR_DATA);
    assign w_push_ok    = w_wr_data && !w_full;
    assign w_pop_ok     = w_rd_data && !w_empty;
    assign w_clr        = mmio_wr_valid && (mmio_wr_addr == ADDR_CTRL) && mmio_wr_data[0];
    assign w_sticky_clr = mmio_wr_valid && (mmio_wr_addr == ADDR_CTRL) && mmio_wr_data[1];

    assign w_status = {43'd0, r_thresh_hit, r_udf, r_ovf, w_full, w_empty, 16'(r_count)};

    // Full/empty gating of push/pop keeps the counter from ever wrapping.
    always_comb begin
        w_count_nxt = r_count;
        if (w_clr) begin
            w_count_nxt = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // DATA reads carry no word here; their data comes from fifo_rdata in S2.
    always_comb begin
        w_rd_word = '0;
        if (mmio_rd_addr == ADDR_STATUS) begin
            w_rd_word = w_status;
        end else if (mmio_rd_addr == ADDR_THRESH) begin
            w_rd_word = 64'(r_thresh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_thresh     <= c_full;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
            r_thresh_hit <= 1'b0;
            r_fifo_push  <= 1'b0;
            r_fifo_wdata <= '0;
            r_fifo_pop   <= 1'b0;
            r_fifo_clr   <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_tid     <= '0;
            r_s1_pop     <= 1'b0;
            r_s1_data    <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_tid     <= '0;
            r_s2_pop     <= 1'b0;
            r_s2_data    <= '0;
        end else begin
            r_count      <= w_count_nxt;
            r_thresh_hit <= (r_count >= r_thresh);
            if (mmio_wr_valid && (mmio_wr_addr == ADDR_THRESH)) begin
                r_thresh <= mmio_wr_data[CW-1:0];
            end
            // A same-cycle error event wins over a sticky clear.
            r_ovf <= (r_ovf && !w_sticky_clr) || (w_wr_data && w_full);
            r_udf <= (r_udf && !w_sticky_clr) || (w_rd_data && w_empty);

            r_fifo_push <= w_push_ok;
            r_fifo_pop  <= w_pop_ok;
            r_fifo_clr  <= w_clr;
            if (w_push_ok) begin
                r_fifo_wdata <= mmio_wr_data;
            end

            r_s1_valid <= mmio_rd_valid;
            r_s1_tid   <= mmio_rd_tid;
            r_s1_pop   <= w_pop_ok;
            r_s1_data  <= mmio_rd_valid ? w_rd_word : 64'd0;

            r_s2_valid <= r_s1_valid;
            r_s2_tid   <= r_s1_tid;
            r_s2_pop   <= r_s1_pop;
            r_s2_data  <= r_s1_data;
        end
    end

    assign fifo_push  = r_fifo_push;
    assign fifo_wdata = r_fifo_wdata;
    assign fifo_pop   = r_fifo_pop;
    assign fifo_clr   = r_fifo_clr;
    assign thresh_hit = r_thresh_hit;
    assign rsp_valid  = r_s2_valid;
    assign rsp_tid    = r_s2_tid;
    // The fifo presents popped data one cycle after the pop, i.e. during S2.
    assign rsp_data   = r_s2_pop ? fifo_rdata : r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_mmio_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_fifo_ctrl
// Description : Self-checking bench for mmio_fifo_ctrl with a behavioural fifo
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_fifo_ctrl;

    localparam int          DEPTH  = 8;
    localparam int          CW     = $clog2(DEPTH + 1);
    localparam logic [15:0] A_DATA = 16'h0020;
    localparam logic [15:0] A_STAT = 16'h0022;
    localparam logic [15:0] A_CTRL = 16'h0024;
    localparam logic [15:0] A_THR  = 16'h0026;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mmio_wr_valid = 1'b0;
    logic [15:0] mmio_wr_addr  = '0;
    logic [63:0] mmio_wr_data  = '0;
    logic        mmio_rd_valid = 1'b0;
    logic [15:0] mmio_rd_addr  = '0;
    logic [8:0]  mmio_rd_tid   = '0;
    logic        fifo_push;
    logic [63:0] fifo_wdata;
    logic        fifo_pop;
    logic        fifo_clr;
    logic [63:0] fifo_rdata = '0;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        thresh_hit;

    mmio_fifo_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_DATA  (A_DATA),
        .ADDR_STATUS(A_STAT),
        .ADDR_CTRL  (A_CTRL),
        .ADDR_THRESH(A_THR)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_wr_addr (mmio_wr_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_rd_addr (mmio_rd_addr),
        .mmio_rd_tid  (mmio_rd_tid),
        .fifo_push    (fifo_push),
        .fifo_wdata   (fifo_wdata),
        .fifo_pop     (fifo_pop),
        .fifo_clr     (fifo_clr),
        .fifo_rdata   (fifo_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .thresh_hit   (thresh_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural fifo: registered head, valid the cycle after a pop.
    logic [63:0] fmem [DEPTH];
    logic [2:0]  fwp = '0;
    logic [2:0]  frp = '0;
    always @(posedge clk) begin
        if (rst || fifo_clr) begin
            fwp <= '0;
            frp <= '0;
        end else begin
            if (fifo_push) begin
                fmem[fwp] <= fifo_wdata;
                fwp       <= fwp + 3'd1;
            end
            if (fifo_pop) begin
                fifo_rdata <= fmem[frp];
                frp        <= frp + 3'd1;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;
    rsp_t sb[$];

    // Reference model state
    logic [63:0]   m_q[$];
    int            m_count;
    logic [CW-1:0] m_thresh;
    logic          m_ovf, m_udf, m_hit;

    always @(negedge clk) begin
        rsp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("rsp_missing", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_spurious", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_tid", 64'(rsp_tid), 64'(e.tid));
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic step(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                        input logic rv, input logic [15:0] ra, input logic [8:0] tid);
        logic        push_ok, pop_ok, clr, sclr, ovf_set, udf_set, hit_new;
        logic [63:0] ed;
        int          nc;
        rsp_t        e;
        mmio_wr_valid = wv;
        mmio_wr_addr  = wa;
        mmio_wr_data  = wd;
        mmio_rd_valid = rv;
        mmio_rd_addr  = ra;
        mmio_rd_tid   = tid;
        push_ok = wv && wa == A_DATA && m_count < DEPTH;
        ovf_set = wv && wa == A_DATA && m_count == DEPTH;
        pop_ok  = rv && ra == A_DATA && m_count > 0;
        udf_set = rv && ra == A_DATA && m_count == 0;
        clr     = wv && wa == A_CTRL && wd[0];
        sclr    = wv && wa == A_CTRL && wd[1];
        if (rv) begin
            ed = '0;
            if (pop_ok)
                ed = m_q.pop_front();
            else if (ra == A_STAT)
                ed = {43'd0, m_hit, m_udf, m_ovf, m_count == DEPTH, m_count == 0, 16'(m_count)};
            else if (ra == A_THR)
                ed = 64'(m_thresh);
            e.cyc  = cyc + 2;
            e.tid  = tid;
            e.data = ed;
            sb.push_back(e);
        end
        if (push_ok) m_q.push_back(wd);
        if (clr) m_q.delete();
        nc = clr ? 0 : m_count + int'(push_ok) - int'(pop_ok);
        hit_new = (m_count >= int'(m_thresh));
        if (sclr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (ovf_set) m_ovf = 1'b1;
        if (udf_set) m_udf = 1'b1;
        if (wv && wa == A_THR) m_thresh = wd[CW-1:0];
        @(posedge clk);
        #1;
        m_count = nc;
        m_hit   = hit_new;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        chk("fifo_push", 64'(fifo_push), 64'(push_ok));
        if (push_ok) chk("fifo_wdata", fifo_wdata, wd);
        chk("fifo_pop", 64'(fifo_pop), 64'(pop_ok));
        chk("fifo_clr", 64'(fifo_clr), 64'(clr));
        chk("thresh_hit", 64'(thresh_hit), 64'(m_hit));
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        step(1'b1, a, d, 1'b0, 16'd0, 9'd0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] tid);
        step(1'b0, 16'd0, 64'd0, 1'b1, a, tid);
    endtask

    task automatic idle();
        step(1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 9'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        sb.delete();
        m_q.delete();
        m_count  = 0;
        m_thresh = CW'(DEPTH);
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_hit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        chk("rst_push", 64'(fifo_push), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_clr", 64'(fifo_clr), 64'd0);
        chk("rst_wdata", fifo_wdata, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_thresh_hit", 64'(thresh_hit), 64'd0);

        // Reset status and tid echo
        rd(A_STAT, 9'h1A5);
        idle();
        idle();

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) wr(A_DATA, 64'hA0 + 64'(i));
        rd(A_STAT, 9'h002);
        wr(A_DATA, 64'hA8);
        idle();
        rd(A_STAT, 9'h003);
        for (int i = 0; i < 8; i++) rd(A_DATA, 9'(16 + i));

        // Underflow and sticky clear
        rd(A_DATA, 9'h030);
        idle();
        rd(A_STAT, 9'h004);
        wr(A_CTRL, 64'h2);
        rd(A_STAT, 9'h005);

        // Back-to-back reads
        for (int i = 0; i < 3; i++) wr(A_DATA, 64'hB0 + 64'(i));
        rd(A_DATA, 9'd1);
        rd(A_DATA, 9'd2);
        rd(A_DATA, 9'd3);
        idle();
        idle();

        // Simultaneous push/pop, then flush behind an in-flight pop
        for (int i = 0; i < 3; i++) wr(A_DATA, 64'hC0 + 64'(i));
        step(1'b1, A_DATA, 64'hC3, 1'b1, A_DATA, 9'd6);
        rd(A_STAT, 9'd7);
        rd(A_DATA, 9'd8);
        wr(A_CTRL, 64'h1);
        rd(A_STAT, 9'd9);

        // Threshold
        wr(A_THR, 64'd4);
        rd(A_THR, 9'd10);
        for (int i = 0; i < 4; i++) wr(A_DATA, 64'hD0 + 64'(i));
        idle();
        rd(A_STAT, 9'd11);
        rd(A_DATA, 9'd12);
        idle();
        idle();
        rd(A_STAT, 9'd13);

        // Underflow with a same-cycle push, unmapped read
        wr(A_CTRL, 64'h3);
        step(1'b1, A_DATA, 64'hE0, 1'b1, A_DATA, 9'd14);
        rd(A_STAT, 9'd15);
        rd(A_DATA, 9'd16);
        rd(A_CTRL, 9'd17);
        idle();
        idle();
        idle();

        // Reset with a read in flight: its response must never appear
        rd(A_STAT, 9'd18);
        do_reset();
        idle();
        idle();
        rd(A_STAT, 9'd19);
        idle();
        idle();
        idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_fifo_ctrl.md
Name: mmio_fifo_ctrl

Overview:
- Sequences the AFU's 64-bit FIFO buffer from decoded MMIO traffic.
- MMIO writes to the DATA address push into the FIFO.
- MMIO reads of DATA pop the FIFO and return the head entry with the correct read-response TID.
- Tracks occupancy and exposes STATUS/CTRL/THRESH registers. Sits between the afu MMIO decode and the fifo instance; the afu muxes its response outputs onto tx.c2.

Parameters:
DEPTH, 8, FIFO entry count; must match the attached fifo; 2..65535.
ADDR_DATA, 16'h0020, MMIO word address of the push/pop data port.
ADDR_STATUS, 16'h0022, MMIO word address of the read-only status register.
ADDR_CTRL, 16'h0024, MMIO word address of the write-only control register.
ADDR_THRESH, 16'h0026, MMIO word address of the R/W occupancy threshold.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mmio_wr_valid  in  1  one-cycle MMIO write strobe
mmio_wr_addr  in  16  write word address
mmio_wr_data  in  64  write data
mmio_rd_valid  in  1  one-cycle MMIO read strobe
mmio_rd_addr  in  16  read word address
mmio_rd_tid  in  9  read TID
fifo_push  out  1  push strobe to fifo
fifo_wdata  out  64  push data
fifo_pop  out  1  pop strobe to fifo
fifo_clr  out  1  one-cycle fifo clear
fifo_rdata  in  64  fifo head data; valid the cycle after fifo_pop
rsp_valid  out  1  read response strobe
rsp_tid  out  9  response TID
rsp_data  out  64  response data
thresh_hit  out  1  registered, high while count >= thresh

Behaviour:
- Single clock; rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - count = 0; overflow and underflow sticky bits = 0.
  - thresh = DEPTH.
  - Read pipeline empty.
- count width is CW = $clog2(DEPTH+1). All count decisions in a cycle use the pre-cycle count.
- Write path: all fifo_* outputs are registered and assert the cycle after the strobe.
  - Write to ADDR_DATA when count < DEPTH: fifo_push = 1 and fifo_wdata = data; count increments.
  - Write to ADDR_DATA when count == DEPTH: no push, overflow is set. Pushing while full is rejected even if a pop occurs in the same cycle.
  - Write to ADDR_CTRL:
    - bit0 = 1: fifo_clr = 1 and count forced to 0. Clear takes priority over any same-cycle pop count change.
    - bit1 = 1: clear both sticky bits.
    - Other bits ignored.
  - Write to ADDR_THRESH: thresh <= data[CW-1:0].
  - Writes to other addresses are ignored.
- Read path: a fixed 2-cycle pipeline. No stalls; a new read is accepted every cycle.
  - Cycle S1 (the cycle after mmio_rd_valid): address class, tid and pop-issued flag are registered.
  - For a read of ADDR_DATA with count > 0: fifo_pop = 1 in S1 and count decrements.
  - For a read of ADDR_DATA with count == 0: no pop, underflow is set, response data = 0.
  - Cycle S2: rsp_valid = 1 and rsp_tid = the captured tid. rsp_data is:
    - DATA read with pop: fifo_rdata.
    - STATUS read: status snapshot captured in S1.
    - THRESH read: zero-extended thresh.
    - Anything else: 0.
  - Read-request-to-rsp_valid latency is exactly 2 cycles for every address.
- Status layout:
  - [15:0] count, zero-extended.
  - [16] empty (count == 0).
  - [17] full (count == DEPTH).
  - [18] overflow sticky.
  - [19] underflow sticky.
  - [20] thresh_hit.
  - [63:21] = 0.
- Simultaneous events:
  - Same-cycle write and read are both processed. Push and pop in one cycle leave count unchanged.
  - A read of ADDR_DATA while count == 0 in the same cycle as a push still underflows.
  - A flush with a pop in flight still delivers the already-popped fifo_rdata in S2.
- count never wraps; it saturates by construction via the full/empty gating.
- rst mid-operation: the pipeline is discarded and no rsp_valid is produced for reads accepted before reset.

Test Plan:
- Reset: after rst, STATUS read returns 64'h10000 (empty) with rsp_valid exactly 2 cycles after the request and tid echoed (e.g. 9'h1A5).
- Fill/drain: push 8 values 64'hA0..A7 into DEPTH=8, then STATUS = count 8, full. Eight DATA reads return A0..A7 in order, and count is 0 at the end.
- Overflow/underflow: a ninth push while full produces no fifo_push and sets status[18]. A DATA read while empty returns 0, produces no fifo_pop and sets status[19]. A CTRL write of 64'h2 clears both bits.
- Back-to-back reads: DATA reads on 3 consecutive cycles with tids 1, 2, 3 give rsp_valid on 3 consecutive cycles with tids 1, 2, 3 and the correct FIFO order.
- Simultaneous: at count = 3, a same-cycle push and DATA read leaves count 3. Flush (CTRL = 1) one cycle after a DATA read still returns the popped value, and count = 0 afterwards.
- Threshold: write THRESH = 4 and push 4 entries; thresh_hit rises the cycle after count reaches 4 and status[20] = 1. After one pop, thresh_hit falls.
